// File: rtl/write_check_sequencer.sv
// Drains host-written words from the write FIFO and presents them to the write-path checker,
// keeping the checker strobe and the pattern-advance strobe in lockstep.
module write_check_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  transfer_len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] data_to_check,
  output logic                  check_for_errors,
  output logic                  enable_pattern,
  output logic                  reset_pattern,
  output logic                  reset_err_counter,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_checked
);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]  words_q, words_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  check_q, check_d;
  logic                  clear_q, clear_d;

  logic start_ok;
  logic len_zero;
  logic pop;
  logic strobe;
  logic retired;

  assign len_zero = (transfer_len == '0);
  assign start_ok = (state_q == StIdle) && start && !abort;
  assign pop      = (state_q == StRun) && !fifo_empty && (remaining_q != '0) && !abort;
  // An in-flight word is dropped on abort so no strobe escapes after it.
  assign strobe   = rd_valid_q && !abort;
  // The last strobe has left the pipe once nothing is pending or being presented.
  assign retired  = (remaining_q == '0) && !rd_valid_q && !check_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = len_zero ? StDone : StClear;
        end
      end
      StClear: state_d = StRun;
      StRun: begin
        if (retired) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    remaining_d = remaining_q;
    words_d     = words_q;
    data_d      = data_q;
    rd_valid_d  = pop;
    check_d     = strobe;
    clear_d     = start_ok && !len_zero;

    if (start_ok && !len_zero) begin
      remaining_d = transfer_len;
    end else if (pop) begin
      remaining_d = remaining_q - LEN_WIDTH'(1);
    end

    if ((state_q == StClear) && !abort) begin
      words_d = '0;
    end else if (strobe) begin
      words_d = words_q + LEN_WIDTH'(1);
      data_d  = fifo_dout;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      words_q     <= '0;
      data_q      <= '0;
      rd_valid_q  <= 1'b0;
      check_q     <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      words_q     <= words_d;
      data_q      <= data_d;
      rd_valid_q  <= rd_valid_d;
      check_q     <= check_d;
      clear_q     <= clear_d;
    end
  end

  assign fifo_rd_en        = pop;
  assign data_to_check     = data_q;
  assign check_for_errors  = check_q;
  assign enable_pattern    = check_q;
  assign reset_pattern     = clear_q;
  assign reset_err_counter = clear_q;
  assign busy              = (state_q == StClear) || (state_q == StRun);
  assign done              = (state_q == StDone);
  assign words_checked     = words_q;

endmodule

// File: tb/tb_write_check_sequencer.sv
// Bench for write_check_sequencer: a behavioural standard-mode FIFO feeds the DUT and a
// scoreboard queue holds the words expected at the checker in FIFO order.
module tb_write_check_sequencer;

  localparam int DW = 32;
  localparam int LW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] transfer_len = '0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd_en;
  logic [DW-1:0] data_to_check;
  logic          check_for_errors;
  logic          enable_pattern;
  logic          reset_pattern;
  logic          reset_err_counter;
  logic          busy;
  logic          done;
  logic [LW-1:0] words_checked;

  logic          push_en = 1'b0;
  logic          fifo_flush = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            pops = 0;
  int            rd_while_empty = 0;
  int            tests_run = 0;
  int            tests_failed = 0;

  always #5 clk = ~clk;

  write_check_sequencer #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .abort            (abort),
    .transfer_len     (transfer_len),
    .fifo_empty       (fifo_empty),
    .fifo_dout        (fifo_dout),
    .fifo_rd_en       (fifo_rd_en),
    .data_to_check    (data_to_check),
    .check_for_errors (check_for_errors),
    .enable_pattern   (enable_pattern),
    .reset_pattern    (reset_pattern),
    .reset_err_counter(reset_err_counter),
    .busy             (busy),
    .done             (done),
    .words_checked    (words_checked)
  );

  // Standard-mode FIFO: data appears on fifo_dout the cycle after the pop.
  always @(posedge clk) begin
    if (fifo_flush) begin
      fifo_q.delete();
    end else begin
      if (fifo_rd_en) begin
        pops <= pops + 1;
        if (fifo_q.size() == 0) rd_while_empty <= rd_while_empty + 1;
        else fifo_dout <= fifo_q.pop_front();
      end
      if (push_en) fifo_q.push_back(push_data);
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic preload(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      push_en   = 1'b1;
      push_data = $urandom | 32'h1;
      exp_q.push_back(push_data);
    end
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic flush();
    @(negedge clk);
    fifo_flush = 1'b1;
    @(negedge clk);
    fifo_flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({fifo_rd_en, check_for_errors, enable_pattern, reset_pattern, reset_err_counter,
         busy, done} !== 7'b0 || data_to_check !== '0 || words_checked !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: ctl=%b data=%h words=%0d, required all zero",
               {fifo_rd_en, check_for_errors, enable_pattern, reset_pattern,
                reset_err_counter, busy, done}, data_to_check, words_checked);
    end
    reset_n = 1'b1;
    preload(6);
    start = 1'b1;
    transfer_len = 6;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (fifo_rd_en !== 1'b1 || check_for_errors !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_run_active: rd_en=%b strobe=%b, required 1 1",
               fifo_rd_en, check_for_errors);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({fifo_rd_en, check_for_errors, enable_pattern, reset_pattern, reset_err_counter,
         busy, done} !== 7'b0 || data_to_check !== '0 || words_checked !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: ctl=%b data=%h words=%0d, required all zero",
               {fifo_rd_en, check_for_errors, enable_pattern, reset_pattern,
                reset_err_counter, busy, done}, data_to_check, words_checked);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++;
      if (fifo_rd_en !== 1'b0 || busy !== 1'b0 || check_for_errors !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_after_reset: rd_en=%b busy=%b strobe=%b, required 0 0 0",
                 fifo_rd_en, busy, check_for_errors);
      end
    end
    flush();
  endtask

  task automatic test_full_rate();
    int n_strb, first, last, rp, re, dn, done_at, pops0;
    logic [DW-1:0] e;
    n_strb = 0; first = -1; last = -1; rp = 0; re = 0; dn = 0; done_at = -1;
    preload(8);
    pops0 = pops;
    start = 1'b1;
    transfer_len = 8;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) begin
        tests_run++;
        if (busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL full_busy: busy=%b, required 1", busy);
        end
      end
      if (check_for_errors === 1'b1) begin
        n_strb++;
        if (first < 0) first = i;
        last = i;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        tests_run++;
        if (data_to_check !== e || enable_pattern !== 1'b1) begin
          tests_failed++;
          $display("FAIL full_data: got %h en=%b, required %h en=1",
                   data_to_check, enable_pattern, e);
        end
      end
      if (reset_pattern === 1'b1) rp++;
      if (reset_err_counter === 1'b1) re++;
      if (done === 1'b1) begin
        dn++;
        done_at = i;
      end
    end
    tests_run++;
    if (n_strb != 8 || last - first != 7) begin
      tests_failed++;
      $display("FAIL full_strobes: got %0d spanning %0d, required 8 spanning 7",
               n_strb, last - first);
    end
    tests_run++;
    if (rp != 1 || re != 1) begin
      tests_failed++;
      $display("FAIL full_clears: got %0d/%0d, required 1/1", rp, re);
    end
    tests_run++;
    if (dn != 1 || done_at != 13) begin
      tests_failed++;
      $display("FAIL full_done: got %0d pulses at %0d, required 1 at 13", dn, done_at);
    end
    tests_run++;
    if (words_checked !== 8 || pops - pops0 != 8) begin
      tests_failed++;
      $display("FAIL full_counts: words=%0d pops=%0d, required 8 8",
               words_checked, pops - pops0);
    end
    flush();
  endtask

  task automatic test_underrun();
    int exp_idx[$];
    int idx, dn, done_at, pops0, bad0;
    logic seen;
    logic [DW-1:0] e, last_data;
    exp_idx = '{4, 8, 9, 23};
    dn = 0; done_at = -1; seen = 1'b0; last_data = '0;
    pops0 = pops;
    bad0  = rd_while_empty;
    start = 1'b1;
    transfer_len = 4;
    push_en = 1'b1;
    push_data = $urandom | 32'h1;
    exp_q.push_back(push_data);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (check_for_errors === 1'b1) begin
        e   = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        idx = (exp_idx.size() != 0) ? exp_idx.pop_front() : -1;
        tests_run++;
        if (data_to_check !== e || i != idx) begin
          tests_failed++;
          $display("FAIL underrun_strobe: got %h at %0d, required %h at %0d",
                   data_to_check, i, e, idx);
        end
        seen = 1'b1;
        last_data = data_to_check;
      end else if (seen && i < 23) begin
        tests_run++;
        if (data_to_check !== last_data) begin
          tests_failed++;
          $display("FAIL underrun_hold: got %h, required %h", data_to_check, last_data);
        end
      end
      if (done === 1'b1) begin
        dn++;
        done_at = i;
      end
      push_en = (i == 5) || (i == 6) || (i == 20);
      if (push_en) begin
        push_data = $urandom | 32'h1;
        exp_q.push_back(push_data);
      end
    end
    tests_run++;
    if (exp_idx.size() != 0 || dn != 1 || done_at != 25) begin
      tests_failed++;
      $display("FAIL underrun_done: missing=%0d done=%0d at %0d, required 0 1 at 25",
               exp_idx.size(), dn, done_at);
    end
    tests_run++;
    if (words_checked !== 4 || pops - pops0 != 4 || rd_while_empty != bad0) begin
      tests_failed++;
      $display("FAIL underrun_counts: words=%0d pops=%0d empty_pops=%0d, required 4 4 0",
               words_checked, pops - pops0, rd_while_empty - bad0);
    end
    flush();
  endtask

  task automatic test_zero_length();
    int rp, dn, done_at, bz, pops0;
    rp = 0; dn = 0; done_at = -1; bz = 0;
    preload(2);
    pops0 = pops;
    start = 1'b1;
    transfer_len = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (reset_pattern === 1'b1 || reset_err_counter === 1'b1) rp++;
      if (busy === 1'b1) bz++;
      if (done === 1'b1) begin
        dn++;
        done_at = i;
      end
    end
    tests_run++;
    if (dn != 1 || done_at != 1) begin
      tests_failed++;
      $display("FAIL zero_done: got %0d pulses at %0d, required 1 at 1", dn, done_at);
    end
    tests_run++;
    if (rp != 0 || bz != 0 || pops - pops0 != 0 || words_checked !== 4) begin
      tests_failed++;
      $display("FAIL zero_quiet: clears=%0d busy=%0d pops=%0d words=%0d, required 0 0 0 4",
               rp, bz, pops - pops0, words_checked);
    end
    flush();
  endtask

  task automatic test_abort();
    int n_strb, dn, pops0;
    logic [DW-1:0] e;
    n_strb = 0; dn = 0;
    preload(12);
    pops0 = pops;
    start = 1'b1;
    transfer_len = 10;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (check_for_errors === 1'b1) begin
        n_strb++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        tests_run++;
        if (data_to_check !== e || n_strb > 3) begin
          tests_failed++;
          $display("FAIL abort_strobe: strobe %0d data %h, required at most 3 with %h",
                   n_strb, data_to_check, e);
        end
      end
      if (done === 1'b1) dn++;
      if (i == 7) begin
        tests_run++;
        if (busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL abort_idle: busy=%b, required 0", busy);
        end
        abort = 1'b0;
      end
      if (i == 6) begin
        abort = 1'b1;
        #1;
        tests_run++;
        if (fifo_rd_en !== 1'b0) begin
          tests_failed++;
          $display("FAIL abort_rd_en: got %b, required 0", fifo_rd_en);
        end
      end
    end
    tests_run++;
    if (n_strb != 3 || dn != 0 || words_checked !== 3 || pops - pops0 != 4) begin
      tests_failed++;
      $display("FAIL abort_counts: strobes=%0d done=%0d words=%0d pops=%0d, required 3 0 3 4",
               n_strb, dn, words_checked, pops - pops0);
    end
    flush();
  endtask

  task automatic test_ignored_start();
    int n_strb, rp, dn, done_at, pops0;
    logic [DW-1:0] e;
    n_strb = 0; rp = 0; dn = 0; done_at = -1;
    preload(6);
    pops0 = pops;
    start = 1'b1;
    transfer_len = 5;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      start = (i == 4);
      if (i == 4) transfer_len = 2;
      if (check_for_errors === 1'b1) begin
        n_strb++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        tests_run++;
        if (data_to_check !== e) begin
          tests_failed++;
          $display("FAIL ignored_data: got %h, required %h", data_to_check, e);
        end
      end
      if (reset_pattern === 1'b1) rp++;
      if (done === 1'b1) begin
        dn++;
        done_at = i;
      end
    end
    tests_run++;
    if (n_strb != 5 || rp != 1 || dn != 1 || done_at != 10) begin
      tests_failed++;
      $display("FAIL ignored_start: strobes=%0d clears=%0d done=%0d at %0d, required 5 1 1 at 10",
               n_strb, rp, dn, done_at);
    end
    tests_run++;
    if (words_checked !== 5 || pops - pops0 != 5) begin
      tests_failed++;
      $display("FAIL ignored_counts: words=%0d pops=%0d, required 5 5",
               words_checked, pops - pops0);
    end
    flush();
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_underrun();
    test_zero_length();
    test_abort();
    test_ignored_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/write_check_sequencer.md
# write_check_sequencer

Sequencer that sits directly upstream of the write-path data checker. It drains host-written 32-bit words from the write FIFO (standard-mode FIFO, one-cycle read latency) and presents each word to the checker. On the same cycle it drives the checker's check strobe and its pattern-advance strobe, so the reference pattern and the received data stay in lockstep. It also clears the checker's error counter and pattern generator at the start of every transfer, counts checked words, and reports completion.

## Interface
Parameters:
- DATA_WIDTH, 32, width of FIFO data and checker data.
- LEN_WIDTH, 32, width of transfer length and word counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a transfer when idle.
- abort  in  1  level; terminates any transfer, highest priority.
- transfer_len  in  LEN_WIDTH  number of words to check; sampled on accepted start.
- fifo_empty  in  1  write FIFO empty flag.
- fifo_dout  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO pop (combinational).
- data_to_check  out  DATA_WIDTH  registered word to checker.
- check_for_errors  out  1  registered; data_to_check holds a new word this cycle.
- enable_pattern  out  1  registered; identical to check_for_errors.
- reset_pattern  out  1  registered; one-cycle pattern generator reset.
- reset_err_counter  out  1  registered; one-cycle error counter clear.
- busy  out  1  high in CLEAR and RUN.
- done  out  1  one-cycle completion pulse.
- words_checked  out  LEN_WIDTH  count of check strobes issued in the current/last transfer.

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - start with transfer_len != 0 -> CLEAR; latch remaining <= transfer_len.
  - start with transfer_len == 0 -> DONE; no clears and words_checked unchanged.
  - start while not IDLE is ignored.
- CLEAR (1 cycle): reset_pattern and reset_err_counter are high for exactly this cycle. words_checked <= 0. Next state RUN.
- RUN:
  - fifo_rd_en = (state==RUN) && !fifo_empty && remaining != 0 && !abort.
  - Each pop decrements remaining.
  - rd_valid <= fifo_rd_en. When rd_valid is high: data_to_check <= fifo_dout, check_for_errors <= 1, enable_pattern <= 1, and words_checked increments. Otherwise both strobes are 0.
  - Leave for DONE when remaining == 0, rd_valid == 0 and check_for_errors == 0, i.e. the last strobe has retired.
- DONE (1 cycle): done = 1, then IDLE.
- abort (any state): next state IDLE. rd_en drops the same cycle. An in-flight rd_valid word is discarded with no strobe. Strobes are 0 from the next edge. done is not pulsed. words_checked holds its value.
- FIFO empty mid-transfer: stall, no strobes, remain in RUN indefinitely.
- data_to_check holds its last value when no strobe is issued.
- Counters are LEN_WIDTH unsigned. remaining never underflows because it is gated at 0. words_checked never exceeds transfer_len.

## Timing
- Reset values: all registered outputs 0, state IDLE, remaining 0. fifo_rd_en is 0 during reset.
- Start accepted at edge T0: CLEAR during T0..T1 (reset pulses visible), RUN from T1.
- First pop no earlier than the cycle after T1 (state==RUN). A pop in cycle N puts the strobe and data in cycle N+2 (registered).
- Throughput: 1 word/clk with a non-empty FIFO.
- For transfer length L with a never-empty FIFO, done is high at cycle T1+L+3 after start.
- Checker alignment: the checker's error counter and pattern generator are cleared at the CLEAR edge. The first check_for_errors/enable_pattern edge compares against the generator's post-reset first value.

## Test plan
- Reset: assert reset_n=0 mid-RUN with the FIFO full -> all outputs 0 immediately, fifo_rd_en 0; after release, state is IDLE and start is required to proceed.
- Full-rate: transfer_len=8, FIFO preloaded with 8 words -> one reset_pattern/reset_err_counter pulse, 8 consecutive strobes with data in FIFO order, words_checked=8, single done pulse, 8 pops exactly.
- Underrun: transfer_len=4, words pushed at cycles 0, 5, 6, 20 -> 4 strobes with gaps matching arrivals, no pop while empty, done after the 4th strobe retires.
- Zero length: start with transfer_len=0 -> done the next cycle, no reset pulses, no pops, words_checked unchanged.
- Abort: transfer_len=10, abort after 3 strobes while a pop is in flight -> no further strobes, no done, IDLE next cycle, words_checked=3.
- Ignored start: second start pulse during RUN with a different length -> the original length is completed and no extra CLEAR pulse occurs.
